// File: rtl/fp_seq_ctrl.sv
// fp_seq_ctrl -- multi-cycle sequencer for the FP arithmetic datapaths.
//
// Walks NUM_STAGES compute stages, one per cycle, raising a one-hot load
// enable and a stage index for the active stage. It has a start/ready
// handshake, latches the operation mode on accept, can skip from stage 0
// straight to the last stage on a special operand, supports abort, and can
// hold the result until it is acknowledged.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   start, mode   request and operation mode (mode latched on accept)
//   special_case  NaN/Inf/zero flag, looked at only in stage 0
//   abort         cancel the operation in RUN or DONE
//   result_ack    consumer took the result (HOLD_RESULT=1 only)
//   op_ready      start is accepted this cycle
//   busy          a compute stage is active
//   stage_load    one-hot load enable of the active stage
//   stage_sel     index of the active stage (0 outside RUN)
//   mode_q        mode latched at the last accept
//   done          result valid
module fp_seq_ctrl #(
  parameter  int NUM_STAGES  = 5,
  parameter  int MODE_W      = 2,
  parameter  int HOLD_RESULT = 1,
  localparam int STAGE_W     = $clog2(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [MODE_W-1:0]     mode,
  input  logic                  special_case,
  input  logic                  abort,
  input  logic                  result_ack,
  output logic                  op_ready,
  output logic                  busy,
  output logic [NUM_STAGES-1:0] stage_load,
  output logic [STAGE_W-1:0]    stage_sel,
  output logic [MODE_W-1:0]     mode_q,
  output logic                  done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [STAGE_W-1:0] LAST = STAGE_W'(NUM_STAGES - 1);

  state_e              state_q, state_d;
  logic [STAGE_W-1:0]  stage_q, stage_d;
  logic [MODE_W-1:0]   mode_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      mode_q  <= mode_d;
    end
  end

  // op_ready is the only output that looks at live inputs: in DONE it opens
  // on result_ack so a new op can be accepted in the same cycle (no bubble).
  always_comb begin
    op_ready = (state_q == S_IDLE) ||
               ((state_q == S_DONE) && ((HOLD_RESULT == 0) || result_ack));
  end

  // Next state
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    mode_d  = mode_q;
    unique case (state_q)
      S_IDLE: begin
        // abort is meaningless here; start is still honoured
        if (start) begin
          state_d = S_RUN;
          stage_d = '0;
          mode_d  = mode;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          stage_d = '0;
        end else if (stage_q == LAST) begin
          state_d = S_DONE;
          stage_d = '0;
        end else if ((stage_q == '0) && special_case) begin
          // special operand: result comes from the last (round) stage only
          stage_d = LAST;
        end else begin
          stage_d = stage_q + STAGE_W'(1);
        end
      end
      S_DONE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (op_ready) begin
          if (start) begin
            state_d = S_RUN;
            stage_d = '0;
            mode_d  = mode;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        stage_d = '0;
      end
    endcase
  end

  // Registered-state output decode
  always_comb begin
    busy       = (state_q == S_RUN);
    done       = (state_q == S_DONE);
    stage_load = '0;
    stage_sel  = '0;
    if (busy) begin
      stage_load = NUM_STAGES'(1) << stage_q;
      stage_sel  = stage_q;
    end
  end

endmodule

// File: tb/tb_fp_seq_ctrl.sv
// Directed bench for fp_seq_ctrl: one instance with held results, one with
// pulsed done. Expected per-cycle outputs are queued as stimulus is applied
// and popped/compared at the falling edge.
module tb_fp_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // instance with HOLD_RESULT=1
  logic       start_h, special_h, abort_h, ack_h;
  logic [1:0] mode_h, modeq_h;
  logic       rdy_h, busy_h, done_h;
  logic [4:0] load_h;
  logic [2:0] sel_h;

  // instance with HOLD_RESULT=0
  logic       start_p, special_p, abort_p, ack_p;
  logic [1:0] mode_p, modeq_p;
  logic       rdy_p, busy_p, done_p;
  logic [4:0] load_p;
  logic [2:0] sel_p;

  fp_seq_ctrl #(.NUM_STAGES(5), .MODE_W(2), .HOLD_RESULT(1)) u_h (
    .clk(clk), .rst(rst), .start(start_h), .mode(mode_h),
    .special_case(special_h), .abort(abort_h), .result_ack(ack_h),
    .op_ready(rdy_h), .busy(busy_h), .stage_load(load_h),
    .stage_sel(sel_h), .mode_q(modeq_h), .done(done_h)
  );

  fp_seq_ctrl #(.NUM_STAGES(5), .MODE_W(2), .HOLD_RESULT(0)) u_p (
    .clk(clk), .rst(rst), .start(start_p), .mode(mode_p),
    .special_case(special_p), .abort(abort_p), .result_ack(ack_p),
    .op_ready(rdy_p), .busy(busy_p), .stage_load(load_p),
    .stage_sel(sel_p), .mode_q(modeq_p), .done(done_p)
  );

  typedef struct packed {
    logic       rdy;
    logic       busy;
    logic       done;
    logic [4:0] load;
    logic [2:0] sel;
    logic [1:0] mode;
  } obs_t;

  obs_t q_h[$];
  obs_t q_p[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic obs_t o_idle(logic [1:0] m);
    return {1'b1, 1'b0, 1'b0, 5'b0, 3'd0, m};
  endfunction

  function automatic obs_t o_run(int k, logic [1:0] m);
    return {1'b0, 1'b1, 1'b0, 5'(1 << k), 3'(k), m};
  endfunction

  function automatic obs_t o_done(logic r, logic [1:0] m);
    return {r, 1'b0, 1'b1, 5'b0, 3'd0, m};
  endfunction

  // queue the stage sequence of an accepted op on the held instance
  task automatic exp_run(logic [1:0] m, bit sp);
    if (sp) begin
      q_h.push_back(o_run(0, m));
      q_h.push_back(o_run(4, m));
    end else begin
      for (int k = 0; k < 5; k++) q_h.push_back(o_run(k, m));
    end
  endtask

  task automatic cmp(string tag, obs_t a, obs_t e);
    nvec++;
    assert (a === e) else begin
      nerr++;
      $error("FAIL %s: observed rdy=%b busy=%b done=%b load=%b sel=%0d mode=%b, expected rdy=%b busy=%b done=%b load=%b sel=%0d mode=%b",
             tag, a.rdy, a.busy, a.done, a.load, a.sel, a.mode,
             e.rdy, e.busy, e.done, e.load, e.sel, e.mode);
    end
  endtask

  // one clock: compare at the falling edge, then advance past the rising edge
  task automatic step(string tag);
    obs_t a;
    @(negedge clk);
    if (q_h.size() == 0) begin
      nvec++;
      nerr++;
      $display("FAIL %s: scoreboard empty for held instance", tag);
    end else begin
      a = {rdy_h, busy_h, done_h, load_h, sel_h, modeq_h};
      cmp({tag, "/h"}, a, q_h.pop_front());
    end
    if (q_p.size() != 0) begin
      a = {rdy_p, busy_p, done_p, load_p, sel_p, modeq_p};
      cmp({tag, "/p"}, a, q_p.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {start_h, special_h, abort_h, ack_h} = '0;
    {start_p, special_p, abort_p, ack_p} = '0;
    mode_h = '0;
    mode_p = '0;
    @(posedge clk);
    #1;

    // reset state; start alongside rst is dropped
    start_h = 1; mode_h = 2'b11;
    q_h.push_back(o_idle(2'b00)); step("rst_start");
    rst = 0; start_h = 0;
    q_h.push_back(o_idle(2'b00)); step("post_rst");
    ack_h = 1;
    q_h.push_back(o_idle(2'b00)); step("ack_idle");
    ack_h = 0;

    // full sequence, then held result
    start_h = 1; mode_h = 2'b01;
    q_h.push_back(o_idle(2'b00)); step("accept1");
    start_h = 0; mode_h = 2'b00;
    exp_run(2'b01, 0);
    repeat (5) step("run1");
    repeat (4) begin
      q_h.push_back(o_done(1'b0, 2'b01)); step("hold");
    end
    // ack + start: back-to-back with new mode
    ack_h = 1; start_h = 1; mode_h = 2'b10;
    q_h.push_back(o_done(1'b1, 2'b01)); step("ack_start");
    ack_h = 0; start_h = 0;
    exp_run(2'b10, 0);
    repeat (5) step("b2b");
    ack_h = 1;
    q_h.push_back(o_done(1'b1, 2'b10)); step("ack_only");
    ack_h = 0;
    q_h.push_back(o_idle(2'b10)); step("idle_after_ack");

    // special operand early exit
    start_h = 1; mode_h = 2'b11;
    q_h.push_back(o_idle(2'b10)); step("accept_sp");
    start_h = 0; special_h = 1;
    exp_run(2'b11, 1);
    repeat (2) step("special");
    special_h = 0; ack_h = 1;
    q_h.push_back(o_done(1'b1, 2'b11)); step("sp_done");
    ack_h = 0;
    q_h.push_back(o_idle(2'b11)); step("sp_idle");

    // abort at stage 2 with a competing start
    start_h = 1; mode_h = 2'b01;
    q_h.push_back(o_idle(2'b11)); step("accept_ab");
    start_h = 0;
    q_h.push_back(o_run(0, 2'b01));
    q_h.push_back(o_run(1, 2'b01));
    repeat (2) step("pre_abort");
    abort_h = 1; start_h = 1; mode_h = 2'b10;
    q_h.push_back(o_run(2, 2'b01)); step("abort");
    abort_h = 0; start_h = 0;
    q_h.push_back(o_idle(2'b01)); step("aborted");
    q_h.push_back(o_idle(2'b01)); step("aborted2");

    // normal op after abort, then abort in DONE
    start_h = 1; mode_h = 2'b11;
    q_h.push_back(o_idle(2'b01)); step("accept_post_ab");
    start_h = 0;
    exp_run(2'b11, 0);
    repeat (5) step("run_post_ab");
    abort_h = 1;
    q_h.push_back(o_done(1'b0, 2'b11)); step("abort_done");
    abort_h = 0;
    q_h.push_back(o_idle(2'b11)); step("aborted_done");

    // abort in IDLE does not block start
    abort_h = 1; start_h = 1; mode_h = 2'b10;
    q_h.push_back(o_idle(2'b11)); step("abort_idle");
    abort_h = 0; start_h = 0;
    for (int k = 0; k < 3; k++) q_h.push_back(o_run(k, 2'b10));
    repeat (3) step("run_to_s3");

    // rst at stage 3, start in same cycle ignored
    rst = 1; start_h = 1; mode_h = 2'b01;
    q_h.push_back(o_run(3, 2'b10)); step("rst_run");
    rst = 0; start_h = 0;
    q_h.push_back(o_idle(2'b00)); step("after_rst_run");

    // rst in DONE
    start_h = 1; mode_h = 2'b01;
    q_h.push_back(o_idle(2'b00)); step("accept_rd");
    start_h = 0;
    exp_run(2'b01, 0);
    repeat (5) step("run_rd");
    rst = 1; start_h = 1;
    q_h.push_back(o_done(1'b0, 2'b01)); step("rst_done");
    rst = 0; start_h = 0;
    q_h.push_back(o_idle(2'b00)); step("after_rst_done");

    // pulsed done: start held high continuously
    start_p = 1; mode_p = 2'b01;
    q_h.push_back(o_idle(2'b00));
    q_p.push_back(o_idle(2'b00)); step("cont_accept");
    repeat (2) begin
      for (int k = 0; k < 5; k++) begin
        q_h.push_back(o_idle(2'b00));
        q_p.push_back(o_run(k, 2'b01)); step("cont_run");
      end
      q_h.push_back(o_idle(2'b00));
      q_p.push_back(o_done(1'b1, 2'b01)); step("cont_done");
    end
    start_p = 0;
    q_h.push_back(o_idle(2'b00));
    q_p.push_back(o_run(0, 2'b01)); step("cont_restart");

    if (q_h.size() != 0 || q_p.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL drain: %0d/%0d expectations left over", q_h.size(), q_p.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
